mem_port_arbiter: RTL

- Shares one single-port synchronous memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage MIPS pipeline.
- Sequences each access through a fixed-latency handshake, returns read data to the winning requester, and raises stall_o so the hazard logic can freeze the pipeline while either requester waits.
- Sits between the pipeline stage registers and the unified memory model.

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Lets the IF stage (instruction fetch) and the MEM stage (load/store) of the
// 5-stage pipeline share one single-port synchronous memory. Each access goes
// through IDLE -> ISSUE -> WAIT -> RESP. Read data is returned to the
// requester that won, and stall_o freezes the pipeline while any requester is
// still waiting.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   if_req_i/addr_i     fetch request (level) and address
//   if_rdata_o/ack_o    fetched word (held after ack) and one-cycle ack pulse
//   dm_req_i/we_i       data request (level); we=1 store, we=0 load
//   dm_addr_i/wdata_i   data address and store data
//   dm_rdata_o/ack_o    load data (held after ack) and one-cycle ack pulse
//   stall_o             pipeline freeze request (combinational)
//   mem_en_o            one-cycle access strobe, high in ISSUE
//   mem_we_o            write enable, qualified by mem_en_o
//   mem_addr_o/wdata_o  memory address and write data, held ISSUE..RESP
//   mem_rdata_i         read data, valid MEM_LATENCY cycles after mem_en_o
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   undefined: fixed priority, DM beats IF on simultaneous requests.
//   defined:   on simultaneous requests the requester not served last wins.
//              The last-owner flag resets to IF, so DM wins the first tie.

`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_ack_o,
    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,
    output logic                  dm_ack_o,
    output logic                  stall_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY must be in 1..15");
    end

    localparam logic [3:0] LatLoad = 4'(MEM_LATENCY - 1);
    localparam logic       OwnerIf = 1'b0;
    localparam logic       OwnerDm = 1'b1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                state_q;
    logic                  owner_q;
    logic [3:0]            cnt_q;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] dm_rdata_q;
    logic                  if_ack_q;
    logic                  dm_ack_q;
    logic                  mem_en_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    logic pick_dm;
    logic owner_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_owner_q;
    // A lone request always wins; on a tie, favour whoever was not granted last.
    assign pick_dm = dm_req_i & (~if_req_i | (last_owner_q == OwnerIf));
`else
    // The MEM-stage instruction is older, so DM always wins a tie.
    assign pick_dm = dm_req_i;
`endif

    assign owner_req = (owner_q == OwnerDm) ? dm_req_i : if_req_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            owner_q     <= OwnerIf;
            cnt_q       <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner_q <= OwnerIf;
`endif
        end else begin
            // Strobes are single-cycle pulses unless a state sets them.
            mem_en_q <= 1'b0;
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (if_req_i || dm_req_i) begin
                        owner_q     <= pick_dm;
                        mem_addr_q  <= pick_dm ? dm_addr_i : if_addr_i;
                        mem_we_q    <= pick_dm & dm_we_i;
                        mem_wdata_q <= pick_dm ? dm_wdata_i : '0;
                        mem_en_q    <= 1'b1;
                        state_q     <= StIssue;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_owner_q <= pick_dm;
`endif
                    end
                end
                StIssue: begin
                    cnt_q   <= LatLoad;
                    state_q <= StWait;
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StResp;
                        // Ack and rdata are registered, so the owner's req is
                        // checked on the capture edge. The rdata registers
                        // serve as the holding register: data is written only
                        // when it will be acked, otherwise it is discarded.
                        if (owner_req) begin
                            if (owner_q == OwnerDm) begin
                                dm_ack_q <= 1'b1;
                                if (!mem_we_q) begin
                                    dm_rdata_q <= mem_rdata_i;
                                end
                            end else begin
                                if_ack_q   <= 1'b1;
                                if_rdata_q <= mem_rdata_i;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign dm_ack_o    = dm_ack_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    // Waiting requesters stall; the ack cycle itself releases the stall.
    assign stall_o = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule
